// File: rtl/vid_pattern_if.sv
// vid_pattern_if: control inputs and registered video outputs of the pattern generator
interface vid_pattern_if #(parameter int BPC = 12);
   logic             enable;
   logic [1:0]       pattern_sel;
   logic [3*BPC-1:0] solid_color;
   logic             vid_de;
   logic             vid_hsync;
   logic             vid_vsync;
   logic [3*BPC-1:0] vid_d;
   logic             frame_start;
   logic [15:0]      frame_cnt;
   modport master (
      input  enable, pattern_sel, solid_color,
      output vid_de, vid_hsync, vid_vsync, vid_d, frame_start, frame_cnt
   );
   modport slave (
      output enable, pattern_sel, solid_color,
      input  vid_de, vid_hsync, vid_vsync, vid_d, frame_start, frame_cnt
   );
endinterface

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: parametrised video timing and test-pattern generator, all outputs registered
module vid_pattern_gen #(
   parameter int   H_FRONT    = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BACK     = 48,
   parameter int   H_ACTIVE   = 640,
   parameter int   V_FRONT    = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BACK     = 33,
   parameter int   V_ACTIVE   = 480,
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   BPC        = 12,
   parameter int   RAMP_SHIFT = 3
) (
   input logic             vid_clk,
   input logic             vid_reset,
   vid_pattern_if.master   bus
);
   localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
   localparam int H_TOTAL = H_BLANK + H_ACTIVE;
   localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
   localparam int V_TOTAL = V_BLANK + V_ACTIVE;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam logic [HW-1:0] HB  = HW'(H_BLANK);
   localparam logic [HW-1:0] HT1 = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HF  = HW'(H_FRONT);
   localparam logic [HW-1:0] HFS = HW'(H_FRONT + H_SYNC);
   localparam logic [HW-1:0] BW1 = HW'(BAR_W - 1);
   localparam logic [VW-1:0] VB  = VW'(V_BLANK);
   localparam logic [VW-1:0] VT1 = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VF  = VW'(V_FRONT);
   localparam logic [VW-1:0] VFS = VW'(V_FRONT + V_SYNC);
   localparam logic [VW-1:0] VA1 = VW'(V_ACTIVE - 1);
   localparam logic [BPC-1:0] MAX = '1;

   logic [HW-1:0]    col_q, col_d, bx_q, bx_d, x;
   logic [VW-1:0]    line_q, line_d, off_q, off_d, y;
   logic [2:0]       bi_q, bi_d;
   logic [1:0]       pat_q, pat_d;
   logic [3*BPC-1:0] clr_q, clr_d, d_q, d_d;
   logic             started_q, started_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [15:0]      fc_q, fc_d;
   logic             en, sof, eol, eof, act, in_act_col, top;
   logic [BPC-1:0]   xs, ys, r, g, b;

   // next-state for counters, running bar index, latched pattern and pixel output
   always_comb begin
      en         = bus.enable;
      sof        = col_q == '0 && line_q == '0;
      eol        = col_q == HT1;
      eof        = eol && line_q == VT1;
      in_act_col = col_q >= HB;
      act        = line_q >= VB && in_act_col;
      x          = col_q - HB;
      y          = line_q - VB;
      xs         = BPC'(32'(x) << RAMP_SHIFT);
      ys         = BPC'(32'(y) << RAMP_SHIFT);
      top        = y < off_q;
      r = pat_q == 2'd0 ? clr_q[3*BPC-1:2*BPC] : pat_q == 2'd1 ? {BPC{~bi_q[1]}} :
          pat_q == 2'd2 ? xs : top ? MAX : ys;
      g = pat_q == 2'd0 ? clr_q[2*BPC-1:BPC] : pat_q == 2'd1 ? {BPC{~bi_q[2]}} :
          pat_q == 2'd2 ? ys : top ? ys : MAX;
      b = pat_q == 2'd0 ? clr_q[BPC-1:0] : pat_q == 2'd1 ? {BPC{~bi_q[0]}} :
          pat_q == 2'd2 ? '0 : xs;
      col_d     = en && !eol ? col_q + 1'b1 : '0;
      line_d    = !en ? '0 : eof ? '0 : eol ? line_q + 1'b1 : line_q;
      off_d     = !en ? '0 : eof ? (off_q == VA1 ? '0 : off_q + 1'b1) : off_q;
      bx_d      = en && in_act_col && bx_q != BW1 ? bx_q + 1'b1 : '0;
      bi_d      = en && in_act_col ? bi_q + {2'b0, bx_q == BW1 && bi_q != 3'd7} : '0;
      pat_d     = sof ? bus.pattern_sel : pat_q;
      clr_d     = sof ? bus.solid_color : clr_q;
      started_d = en && (started_q || sof);
      de_d      = en && act;
      hs_d      = en && col_q >= HF && col_q < HFS ? HS_POL : ~HS_POL;
      vs_d      = en && line_q >= VF && line_q < VFS ? VS_POL : ~VS_POL;
      fs_d      = en && sof;
      d_d       = en && act ? {r, g, b} : '0;
      fc_d      = fc_q + 16'(en && sof && started_q);
   end

   // state and output registers with synchronous reset
   always_ff @(posedge vid_clk) begin
      if (vid_reset) begin
         col_q     <= '0;
         line_q    <= '0;
         off_q     <= '0;
         bx_q      <= '0;
         bi_q      <= '0;
         pat_q     <= '0;
         clr_q     <= '0;
         started_q <= 1'b0;
         de_q      <= 1'b0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
         fs_q      <= 1'b0;
         d_q       <= '0;
         fc_q      <= '0;
      end else begin
         col_q     <= col_d;
         line_q    <= line_d;
         off_q     <= off_d;
         bx_q      <= bx_d;
         bi_q      <= bi_d;
         pat_q     <= pat_d;
         clr_q     <= clr_d;
         started_q <= started_d;
         de_q      <= de_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         fs_q      <= fs_d;
         d_q       <= d_d;
         fc_q      <= fc_d;
      end
   end

   assign bus.vid_de      = de_q;
   assign bus.vid_hsync   = hs_q;
   assign bus.vid_vsync   = vs_q;
   assign bus.vid_d       = d_q;
   assign bus.frame_start = fs_q;
   assign bus.frame_cnt   = fc_q;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: directed checks of timing, patterns, frame switching and reset on a small raster
module tb_vid_pattern_gen;
   localparam int HT = 24;
   localparam int FR = 192;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pos = 0;
   int   cnt_hs, cnt_de;

   vid_pattern_if #(.BPC(12)) bus ();

   vid_pattern_gen #(
      .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .H_ACTIVE(16),
      .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4),
      .HS_POL(1'b0), .VS_POL(1'b1), .BPC(12), .RAMP_SHIFT(3)
   ) dut (
      .vid_clk(clk),
      .vid_reset(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
      pos += n;
   endtask

   // advance until the output reflects counter state (col c, line l) of frame f since enable
   task automatic goto(input int f, input int l, input int c);
      int t;
      t = 1 + f * FR + l * HT + c;
      if (t > pos) step(t - pos);
   endtask

   task automatic px(input string tag, input int f, input int l, input int c, input logic [35:0] exp);
      goto(f, l, c);
      check({tag, "_de"}, 64'(bus.vid_de), 64'd1);
      check(tag, 64'(bus.vid_d), 64'(exp));
   endtask

   initial begin
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.pattern_sel = 2'd0;
      bus.solid_color = 36'h123456789;
      step(3);
      check("rst_de", 64'(bus.vid_de), 64'd0);
      check("rst_hs", 64'(bus.vid_hsync), 64'd1);
      check("rst_vs", 64'(bus.vid_vsync), 64'd0);
      check("rst_d", 64'(bus.vid_d), 64'd0);
      check("rst_fs", 64'(bus.frame_start), 64'd0);
      check("rst_fc", 64'(bus.frame_cnt), 64'd0);
      rst = 1'b0;
      bus.enable = 1'b1;
      pos = 0;
      goto(0, 0, 0);
      check("f0_fs", 64'(bus.frame_start), 64'd1);
      check("f0_hs", 64'(bus.vid_hsync), 64'd1);
      check("f0_vs", 64'(bus.vid_vsync), 64'd0);
      check("f0_fc", 64'(bus.frame_cnt), 64'd0);
      goto(0, 0, 1);
      check("fs_pulse", 64'(bus.frame_start), 64'd0);
      goto(0, 0, 2);
      check("hs_on", 64'(bus.vid_hsync), 64'd0);
      goto(0, 0, 4);
      check("hs_last", 64'(bus.vid_hsync), 64'd0);
      goto(0, 0, 5);
      check("hs_off", 64'(bus.vid_hsync), 64'd1);
      goto(0, 1, 0);
      check("vs_on", 64'(bus.vid_vsync), 64'd1);
      goto(0, 2, 0);
      check("vs_off", 64'(bus.vid_vsync), 64'd0);
      goto(0, 3, 0);
      cnt_hs = 0;
      cnt_de = 0;
      for (int i = 0; i < HT; i++) begin
         cnt_hs += int'(!bus.vid_hsync);
         cnt_de += int'(bus.vid_de);
         step(1);
      end
      check("hs_count", 64'(cnt_hs), 64'd3);
      check("de_blank_line", 64'(cnt_de), 64'd0);
      cnt_de = 0;
      for (int i = 0; i < HT; i++) begin
         cnt_de += int'(bus.vid_de);
         step(1);
      end
      check("de_count", 64'(cnt_de), 64'd16);
      goto(0, 5, 7);
      check("de_pre", 64'(bus.vid_de), 64'd0);
      check("d_blank", 64'(bus.vid_d), 64'd0);
      px("solid", 0, 5, 8, 36'h123456789);
      bus.pattern_sel = 2'd2;
      bus.solid_color = 36'hABCABCABC;
      px("solid_hold", 0, 6, 9, 36'h123456789);
      px("solid_end", 0, 7, 23, 36'h123456789);
      goto(1, 0, 0);
      check("f1_fs", 64'(bus.frame_start), 64'd1);
      check("f1_fc", 64'(bus.frame_cnt), 64'd1);
      px("ramp_1_1", 1, 5, 9, 36'h008008000);
      px("ramp_2_2", 1, 6, 10, 36'h010010000);
      bus.pattern_sel = 2'd1;
      px("bar_x0", 2, 4, 8, 36'hFFFFFFFFF);
      px("bar_x1", 2, 4, 9, 36'hFFFFFFFFF);
      px("bar_x2", 2, 4, 10, 36'hFFFFFF000);
      px("bar_x4", 2, 4, 12, 36'h000FFFFFF);
      px("bar_x6", 2, 4, 14, 36'h000FFF000);
      px("bar_x8", 2, 4, 16, 36'hFFF000FFF);
      px("bar_x15", 2, 4, 23, 36'h000000000);
      bus.pattern_sel = 2'd3;
      px("split3_y0", 3, 4, 9, 36'hFFF000008);
      px("split3_y2", 3, 6, 11, 36'hFFF010018);
      px("split3_y3", 3, 7, 8, 36'h018FFF000);
      goto(4, 0, 0);
      check("f4_fc", 64'(bus.frame_cnt), 64'd4);
      px("split4_y0", 4, 4, 13, 36'h000FFF028);
      px("split5_y0", 5, 4, 8, 36'hFFF000000);
      px("split5_y1", 5, 5, 8, 36'h008FFF000);
      goto(5, 5, 12);
      rst = 1'b1;
      step(1);
      check("mrst_de", 64'(bus.vid_de), 64'd0);
      check("mrst_d", 64'(bus.vid_d), 64'd0);
      check("mrst_hs", 64'(bus.vid_hsync), 64'd1);
      check("mrst_vs", 64'(bus.vid_vsync), 64'd0);
      check("mrst_fc", 64'(bus.frame_cnt), 64'd0);
      rst = 1'b0;
      bus.enable = 1'b0;
      step(100);
      check("dis_de", 64'(bus.vid_de), 64'd0);
      check("dis_hs", 64'(bus.vid_hsync), 64'd1);
      check("dis_fs", 64'(bus.frame_start), 64'd0);
      check("dis_fc", 64'(bus.frame_cnt), 64'd0);
      bus.enable = 1'b1;
      pos = 0;
      goto(0, 0, 0);
      check("re_fs", 64'(bus.frame_start), 64'd1);
      check("re_fc", 64'(bus.frame_cnt), 64'd0);
      px("re_x0", 0, 4, 8, 36'h000FFF000);
      px("re_x2", 0, 4, 10, 36'h000FFF010);
      goto(1, 0, 0);
      check("re_f1_fc", 64'(bus.frame_cnt), 64'd1);
      px("re_f1_split", 1, 4, 9, 36'hFFF000008);
      bus.enable = 1'b0;
      step(1);
      check("hold_de", 64'(bus.vid_de), 64'd0);
      check("hold_d", 64'(bus.vid_d), 64'd0);
      step(9);
      check("hold_fc", 64'(bus.frame_cnt), 64'd1);
      bus.enable = 1'b1;
      pos = 0;
      goto(0, 0, 0);
      check("en2_fs", 64'(bus.frame_start), 64'd1);
      check("en2_fc", 64'(bus.frame_cnt), 64'd1);
      px("en2_split", 0, 4, 9, 36'h000FFF008);
      goto(1, 0, 0);
      check("en2_f1_fc", 64'(bus.frame_cnt), 64'd2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
